// File: rtl/boot_ahb_writer_if.sv
// boot_ahb_writer_if: image word stream plus AHB-Lite master signals
// between the SPI boot writer and the RAM fabric.
interface boot_ahb_writer_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic [31:0] spi_haddr;
  logic [1:0]  spi_htrans;
  logic        spi_hwrite;
  logic [2:0]  spi_hsize;
  logic [2:0]  spi_hburst;
  logic [3:0]  spi_hprot;
  logic        spi_hmastlock;
  logic [31:0] spi_hwdata;
  logic        spi_hready;
  logic        spi_hresp;

  modport master (
    input  word_valid,
    input  word_data,
    output word_ready,
    output spi_haddr,
    output spi_htrans,
    output spi_hwrite,
    output spi_hsize,
    output spi_hburst,
    output spi_hprot,
    output spi_hmastlock,
    output spi_hwdata,
    input  spi_hready,
    input  spi_hresp
  );

  modport slave (
    output word_valid,
    output word_data,
    input  word_ready,
    input  spi_haddr,
    input  spi_htrans,
    input  spi_hwrite,
    input  spi_hsize,
    input  spi_hburst,
    input  spi_hprot,
    input  spi_hmastlock,
    input  spi_hwdata,
    output spi_hready,
    output spi_hresp
  );
endinterface

// File: rtl/boot_ahb_writer.sv
// boot_ahb_writer: drains SPI boot image words through a small FIFO
// into RAM as single AHB-Lite NONSEQ word writes.
module boot_ahb_writer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [15:0]       start_addr,
  input  logic [15:0]       num_bytes,
  boot_ahb_writer_if.master bus,
  output logic              core_rst,
  output logic              done,
  output logic              error
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ADDR,
    S_DATA, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop, beat_ok;
  logic [31:0] addr_q, data_q;
  logic [16:0] rem_q, words;

  assign words = ({1'b0, num_bytes} + 17'd3) >> 2;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push  = bus.word_valid && bus.word_ready;
  assign beat_ok = (state == S_DATA) &&
                   bus.spi_hready && !bus.spi_hresp;

  assign bus.spi_haddr     = addr_q;
  assign bus.spi_hwdata    = data_q;
  assign bus.spi_hsize     = 3'b010;
  assign bus.spi_hburst    = 3'b000;
  assign bus.spi_hprot     = 4'b0011;
  assign bus.spi_hmastlock = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ERROR is taken on its first cycle, without waiting for hready
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE:
        if (load_start)
          state_nxt = (words == '0) ? S_DONE : S_FILL;
      S_FILL:
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ADDR;
        end
      S_ADDR:
        if (bus.spi_hready) state_nxt = S_DATA;
      S_DATA:
        if (bus.spi_hresp) begin
          state_nxt = S_ERR;
        end else if (bus.spi_hready) begin
          if (rem_q == 17'd1) begin
            state_nxt = S_DONE;
          end else if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_FILL;
          end
        end
      S_DONE, S_ERR: ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.spi_htrans = 2'b00;
    bus.spi_hwrite = 1'b0;
    bus.word_ready = 1'b0;
    core_rst       = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    unique case (state)
      S_FILL, S_DATA:
        bus.word_ready = !full;
      S_ADDR: begin
        bus.spi_htrans = 2'b10;
        bus.spi_hwrite = 1'b1;
        bus.word_ready = !full;
      end
      S_DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr_q <= '0;
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_q <= mem[rd_ptr[PW-1:0]];
      end
      if (state == S_IDLE && load_start) begin
        addr_q <= BASE_ADDR +
                  {16'h0, start_addr & 16'hfffc};
        rem_q  <= words;
      end
      if (beat_ok) begin
        addr_q <= addr_q + 32'd4;
        rem_q  <= rem_q - 17'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= bus.word_data;
  end
endmodule
